// File: rtl/rx_string_packer.sv
// rx_string_packer: packs UART rx bytes into an MSB-first string register.
// A message closes on CR/LF, on reaching MAX_CHARS, or on an inter-byte
// timeout. It is then held on o_string/o_len with o_valid high until the
// consumer acks it.
module rx_string_packer #(
  parameter int unsigned MAX_CHARS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_RX_dv,
  input  logic [7:0]             i_RX_byte,
  input  logic                   i_ack,
  output logic [8*MAX_CHARS-1:0] o_string,
  output logic [CNT_W-1:0]       o_len,
  output logic                   o_valid,
  output logic                   o_overrun
);

  localparam int unsigned SW = 8 * MAX_CHARS;
  localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_CHARS - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_d;
  logic [SW-1:0]   string_d;
  logic [CNT_W-1:0] len_d;
  logic            valid_d;
  logic            overrun_d;
  logic            is_term;
  logic [SW-1:0]   byte_ext;

  assign is_term  = (i_RX_byte == 8'h0D) || (i_RX_byte == 8'h0A);
  assign byte_ext = SW'(i_RX_byte);

  // State register plus the registered outputs and idle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      o_string  <= '0;
      o_len     <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      o_string  <= string_d;
      o_len     <= len_d;
      o_valid   <= valid_d;
      o_overrun <= overrun_d;
    end
  end

  // Next-state: close on terminator, full buffer or timeout; leave HOLD on ack.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (i_RX_dv && !is_term) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (i_RX_dv) begin
          if (is_term || (o_len == LEN_LAST)) state_d = S_HOLD;
        end else if (TMO_EN && (timer == TMO_LAST)) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_ack) begin
          if (i_RX_dv && !is_term) state_d = S_COLLECT;
          else                     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: shift-in, clear on release, sticky overrun.
  always_comb begin
    string_d  = o_string;
    len_d     = o_len;
    overrun_d = o_overrun;
    timer_d   = '0;
    valid_d   = (state_d == S_HOLD);
    case (state)
      S_IDLE: begin
        if (i_RX_dv && !is_term) begin
          string_d = byte_ext;
          len_d    = CNT_W'(1);
        end
      end
      S_COLLECT: begin
        if (i_RX_dv) begin
          if (!is_term) begin
            string_d = (o_string << 8) | byte_ext;
            len_d    = o_len + CNT_W'(1);
          end
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_HOLD: begin
        if (i_ack) begin
          if (i_RX_dv && !is_term) begin
            string_d = byte_ext;
            len_d    = CNT_W'(1);
          end else begin
            string_d = '0;
            len_d    = '0;
          end
        end else if (i_RX_dv) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        string_d = '0;
        len_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_string_packer.sv
// Testbench for rx_string_packer: three instances (default, MAX_CHARS=4,
// TIMEOUT_CYCLES=10) driven with directed byte streams; expected messages
// are queued at stimulus time and checked by per-instance monitors.
module tb_rx_string_packer;

  typedef struct {
    logic [127:0] s;
    int           len;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       dv  [3];
  logic [7:0] rxb [3];
  logic       ack [3];

  logic [127:0] str_a;  logic [4:0] len_a;  logic val_a;  logic ovr_a;
  logic [31:0]  str_b;  logic [4:0] len_b;  logic val_b;  logic ovr_b;
  logic [127:0] str_c;  logic [4:0] len_c;  logic val_c;  logic ovr_c;

  rx_string_packer #(.MAX_CHARS(16), .TIMEOUT_CYCLES(0), .CNT_W(5)) u_a (
    .clk(clk), .rst(rst[0]), .i_RX_dv(dv[0]), .i_RX_byte(rxb[0]), .i_ack(ack[0]),
    .o_string(str_a), .o_len(len_a), .o_valid(val_a), .o_overrun(ovr_a));

  rx_string_packer #(.MAX_CHARS(4), .TIMEOUT_CYCLES(0), .CNT_W(5)) u_b (
    .clk(clk), .rst(rst[1]), .i_RX_dv(dv[1]), .i_RX_byte(rxb[1]), .i_ack(ack[1]),
    .o_string(str_b), .o_len(len_b), .o_valid(val_b), .o_overrun(ovr_b));

  rx_string_packer #(.MAX_CHARS(16), .TIMEOUT_CYCLES(10), .CNT_W(5)) u_c (
    .clk(clk), .rst(rst[2]), .i_RX_dv(dv[2]), .i_RX_byte(rxb[2]), .i_ack(ack[2]),
    .o_string(str_c), .o_len(len_c), .o_valid(val_c), .o_overrun(ovr_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_msg(input string tag, input logic [127:0] s, input int len,
                         input int cy, input exp_t e);
    chk({tag, " string"}, s, e.s);
    chk({tag, " len"}, 128'(len), 128'(e.len));
    chk({tag, " valid cycle"}, 128'(cy), 128'(e.cyc));
  endtask

  task automatic no_exp(input string tag, input int len);
    n_cmp++;
    n_err++;
    $display("FAIL %s unexpected o_valid: got message len %0d, expected none", tag, len);
  endtask

  // Monitors: compare each new o_valid against the head of its queue.
  logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
  always @(negedge clk) begin
    if (val_a && !pv_a) begin
      if (q_a.size() == 0) no_exp("A", int'(len_a));
      else cmp_msg("A", str_a, int'(len_a), cyc, q_a.pop_front());
    end
    pv_a <= val_a;
  end
  always @(negedge clk) begin
    if (val_b && !pv_b) begin
      if (q_b.size() == 0) no_exp("B", int'(len_b));
      else cmp_msg("B", 128'(str_b), int'(len_b), cyc, q_b.pop_front());
    end
    pv_b <= val_b;
  end
  always @(negedge clk) begin
    if (val_c && !pv_c) begin
      if (q_c.size() == 0) no_exp("C", int'(len_c));
      else cmp_msg("C", str_c, int'(len_c), cyc, q_c.pop_front());
    end
    pv_c <= val_c;
  end

  // One cycle of stimulus on instance idx; returns cycle number of the sampling edge.
  task automatic drive(input int idx, input logic d, input logic [7:0] b,
                       input logic a, output int c);
    dv[idx]  = d;
    rxb[idx] = b;
    ack[idx] = a;
    @(posedge clk);
    #1;
    c = cyc;
    dv[idx]  = 1'b0;
    rxb[idx] = 8'h00;
    ack[idx] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [127:0] s, input int len, input int cy);
    exp_t e;
    e.s = s;
    e.len = len;
    e.cyc = cy;
    return e;
  endfunction

  int c;
  logic [127:0] e16;
  logic [7:0]   b;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; dv[i] = 1'b0; rxb[i] = 8'h00; ack[i] = 1'b0;
    end
    idle(2);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Reset state.
    chk("reset string", str_a, 128'h0);
    chk("reset len", 128'(len_a), 128'(0));
    chk("reset valid", 128'(val_a), 128'(0));
    chk("reset overrun", 128'(ovr_a), 128'(0));

    // Empty lines in IDLE are dropped.
    drive(0, 1'b1, 8'h0A, 1'b0, c);
    drive(0, 1'b1, 8'h0D, 1'b0, c);
    idle(1);
    chk("empty line valid", 128'(val_a), 128'(0));
    chk("empty line len", 128'(len_a), 128'(0));

    // "AAAB" + CR.
    drive(0, 1'b1, 8'h41, 1'b0, c);
    drive(0, 1'b1, 8'h41, 1'b0, c);
    drive(0, 1'b1, 8'h41, 1'b0, c);
    drive(0, 1'b1, 8'h42, 1'b0, c);
    drive(0, 1'b1, 8'h0D, 1'b0, c);
    q_a.push_back(mk(128'h41414142, 4, c));
    idle(3);
    chk("hold valid stays", 128'(val_a), 128'(1));

    // Byte in HOLD without ack is dropped and flagged.
    drive(0, 1'b1, 8'h51, 1'b0, c);
    chk("overrun set", 128'(ovr_a), 128'(1));
    chk("hold string frozen", str_a, 128'h41414142);
    chk("hold len frozen", 128'(len_a), 128'(4));

    // Ack together with "R" starts a new message.
    drive(0, 1'b1, 8'h52, 1'b1, c);
    chk("ack+R valid", 128'(val_a), 128'(0));
    chk("ack+R len", 128'(len_a), 128'(1));
    chk("ack+R string", str_a, 128'h52);
    drive(0, 1'b1, 8'h0D, 1'b0, c);
    q_a.push_back(mk(128'h52, 1, c));
    drive(0, 1'b0, 8'h00, 1'b1, c);
    chk("ack clear valid", 128'(val_a), 128'(0));
    chk("ack clear len", 128'(len_a), 128'(0));
    chk("ack clear string", str_a, 128'h0);
    chk("overrun sticky", 128'(ovr_a), 128'(1));
    drive(0, 1'b0, 8'h00, 1'b1, c);
    chk("ack in idle ignored", 128'(val_a), 128'(0));

    // Sixteen characters close the message without a terminator.
    e16 = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'h61 + 8'(i);
      e16 = {e16[119:0], b};
      drive(0, 1'b1, b, 1'b0, c);
    end
    q_a.push_back(mk(e16, 16, c));
    idle(2);
    chk("full len", 128'(len_a), 128'(16));
    drive(0, 1'b0, 8'h00, 1'b1, c);

    // Reset mid-message discards everything, including overrun.
    drive(0, 1'b1, 8'h58, 1'b0, c);
    drive(0, 1'b1, 8'h59, 1'b0, c);
    drive(0, 1'b1, 8'h5A, 1'b0, c);
    chk("pre-reset len", 128'(len_a), 128'(3));
    rst[0] = 1'b1;
    idle(1);
    rst[0] = 1'b0;
    chk("mid rst string", str_a, 128'h0);
    chk("mid rst len", 128'(len_a), 128'(0));
    chk("mid rst valid", 128'(val_a), 128'(0));
    chk("mid rst overrun", 128'(ovr_a), 128'(0));
    drive(0, 1'b1, 8'h5A, 1'b0, c);
    drive(0, 1'b1, 8'h0D, 1'b0, c);
    q_a.push_back(mk(128'h5A, 1, c));
    idle(2);
    drive(0, 1'b0, 8'h00, 1'b1, c);

    // MAX_CHARS=4: "WXYZ" closes on the fourth byte.
    drive(1, 1'b1, 8'h57, 1'b0, c);
    drive(1, 1'b1, 8'h58, 1'b0, c);
    drive(1, 1'b1, 8'h59, 1'b0, c);
    chk("B not early", 128'(val_b), 128'(0));
    drive(1, 1'b1, 8'h5A, 1'b0, c);
    q_b.push_back(mk(128'h5758595A, 4, c));
    idle(2);
    chk("B len saturated", 128'(len_b), 128'(4));
    drive(1, 1'b0, 8'h00, 1'b1, c);

    // TIMEOUT_CYCLES=10: "HI" then silence.
    drive(2, 1'b1, 8'h48, 1'b0, c);
    drive(2, 1'b1, 8'h49, 1'b0, c);
    q_c.push_back(mk(128'h4849, 2, c + 10));
    idle(9);
    chk("C not before timeout", 128'(val_c), 128'(0));
    idle(3);
    chk("C overrun clear", 128'(ovr_c), 128'(0));
    drive(2, 1'b0, 8'h00, 1'b1, c);

    idle(3);
    chk("A messages seen", 128'(q_a.size()), 128'(0));
    chk("B messages seen", 128'(q_b.size()), 128'(0));
    chk("C messages seen", 128'(q_c.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
